// File: rtl/spectrum_bin_ranker.sv
// rtl/spectrum_bin_ranker.sv - streaming FFT bin magnitude, per-bin peak hold and top-K ranking
module spectrum_bin_ranker #(
  parameter int SAMPLES     = 16,
  parameter int WIDTH       = 32,
  parameter int SCALER      = 1,
  parameter int TOP_K       = 3,
  parameter int DECAY_SHIFT = 3,
  localparam int IW = $clog2(SAMPLES),
  localparam int MW = WIDTH/2 + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin_data,
  input  logic                  bin_last,
  input  logic                  hold_en,
  output logic [TOP_K*IW-1:0]   top_idx,
  output logic [TOP_K*MW-1:0]   top_mag,
  output logic                  frame_done,
  output logic                  frame_error
);
  localparam int HW = WIDTH/2;

  typedef enum logic [1:0] {S_ACCEPT, S_DRAIN, S_PUBLISH} state_t;

  state_t            r_state;
  logic              r_drain_cnt;
  logic [IW-1:0]     r_cnt;
  logic              r_hold_frame;
  logic              r_s1_vld;
  logic [IW-1:0]     r_s1_idx;
  logic [MW-1:0]     r_s1_mag;
  logic              r_s1_hold;
  logic [MW-1:0]     r_held [SAMPLES];
  logic [IW-1:0]     r_lidx [TOP_K];
  logic [MW-1:0]     r_lmag [TOP_K];
  logic [TOP_K-1:0]  r_lval;

  logic              w_xfer;
  logic              w_first;
  logic              w_at_end;
  logic [HW-1:0]     w_re;
  logic [HW-1:0]     w_im;
  logic [HW-1:0]     w_re_abs;
  logic [HW-1:0]     w_im_abs;
  logic [MW-1:0]     w_mag_sum;
  logic [MW-1:0]     w_mag;
  logic [MW-1:0]     w_old;
  logic [MW-1:0]     w_cand;
  logic [MW-1:0]     w_new;
  logic              w_start;
  logic [TOP_K-1:0]  w_eval;
  logic [TOP_K-1:0]  w_gt;
  logic [IW-1:0]     w_nidx [TOP_K];
  logic [MW-1:0]     w_nmag [TOP_K];
  logic [TOP_K-1:0]  w_nval;

  assign in_ready = (r_state == S_ACCEPT) && !reset;
  assign w_xfer   = in_valid && in_ready;
  assign w_first  = (r_cnt == '0);
  assign w_at_end = (r_cnt == IW'(SAMPLES-1));

  // Unsigned abs in HW bits keeps -2^(HW-1) exact as 2^(HW-1).
  assign w_re      = bin_data[WIDTH-1:HW];
  assign w_im      = bin_data[HW-1:0];
  assign w_re_abs  = w_re[HW-1] ? (~w_re + 1'b1) : w_re;
  assign w_im_abs  = w_im[HW-1] ? (~w_im + 1'b1) : w_im;
  assign w_mag_sum = {1'b0, w_re_abs} + {1'b0, w_im_abs};
  assign w_mag     = w_mag_sum >> SCALER;

  // With DECAY_SHIFT=0 the candidate decays to zero, so held simply follows mag.
  assign w_old  = r_held[r_s1_idx];
  assign w_cand = w_old - (w_old >> DECAY_SHIFT);
  assign w_new  = (r_s1_hold && (w_cand > r_s1_mag)) ? w_cand : r_s1_mag;
  assign w_start = (r_s1_idx == '0);

  always_comb begin
    for (int j = 0; j < TOP_K; j++) begin
      w_eval[j] = r_lval[j] && !w_start;
      w_gt[j]   = !w_eval[j] || (w_new > r_lmag[j]);
    end
  end

  // Descending insertion: slots at or below the insert point shift down by one.
  always_comb begin
    for (int j = 0; j < TOP_K; j++) begin
      w_nidx[j] = r_lidx[j];
      w_nmag[j] = r_lmag[j];
      w_nval[j] = w_eval[j];
    end
    if (w_gt[0]) begin
      w_nidx[0] = r_s1_idx;
      w_nmag[0] = w_new;
      w_nval[0] = 1'b1;
    end
    for (int j = 1; j < TOP_K; j++) begin
      if (w_gt[j]) begin
        if (!w_gt[j-1]) begin
          w_nidx[j] = r_s1_idx;
          w_nmag[j] = w_new;
          w_nval[j] = 1'b1;
        end else begin
          w_nidx[j] = r_lidx[j-1];
          w_nmag[j] = r_lmag[j-1];
          w_nval[j] = w_eval[j-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_ACCEPT;
      r_drain_cnt  <= 1'b0;
      r_cnt        <= '0;
      r_hold_frame <= 1'b0;
      r_s1_vld     <= 1'b0;
      r_s1_idx     <= '0;
      r_s1_mag     <= '0;
      r_s1_hold    <= 1'b0;
      r_lval       <= '0;
      for (int i = 0; i < SAMPLES; i++) r_held[i] <= '0;
      for (int j = 0; j < TOP_K; j++) begin
        r_lidx[j] <= '0;
        r_lmag[j] <= '0;
      end
      top_idx     <= '0;
      top_mag     <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      r_s1_vld    <= w_xfer;
      if (w_xfer) begin
        r_s1_idx  <= r_cnt;
        r_s1_mag  <= w_mag;
        r_s1_hold <= w_first ? hold_en : r_hold_frame;
        if (w_first) r_hold_frame <= hold_en;
      end
      if (r_s1_vld) begin
        r_held[r_s1_idx] <= w_new;
        r_lval <= w_nval;
        for (int j = 0; j < TOP_K; j++) begin
          r_lidx[j] <= w_nidx[j];
          r_lmag[j] <= w_nmag[j];
        end
      end
      case (r_state)
        S_ACCEPT: begin
          if (w_xfer) begin
            if (bin_last != w_at_end) begin
              frame_error <= 1'b1;
              r_cnt       <= '0;
            end else if (bin_last) begin
              r_cnt       <= '0;
              r_drain_cnt <= 1'b0;
              r_state     <= S_DRAIN;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt) begin
            r_state    <= S_PUBLISH;
            frame_done <= 1'b1;
            for (int j = 0; j < TOP_K; j++) begin
              top_idx[j*IW +: IW] <= r_lidx[j];
              top_mag[j*MW +: MW] <= r_lmag[j];
            end
          end else begin
            r_drain_cnt <= 1'b1;
          end
        end
        default: r_state <= S_ACCEPT;
      endcase
    end
  end
endmodule

// File: tb/tb_spectrum_bin_ranker.sv
// tb/tb_spectrum_bin_ranker.sv - directed self-checking bench for spectrum_bin_ranker
module tb_spectrum_bin_ranker;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_ready0;
  logic [31:0] bin_data;
  logic        bin_last;
  logic        hold_en;
  logic [11:0] top_idx;
  logic [50:0] top_mag;
  logic        frame_done;
  logic        frame_error;
  logic [11:0] top_idx0;
  logic [50:0] top_mag0;
  logic        frame_done0;
  logic        frame_error0;

  logic [15:0] re_v [16];
  logic [15:0] im_v [16];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  spectrum_bin_ranker u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .bin_data(bin_data), .bin_last(bin_last), .hold_en(hold_en),
    .top_idx(top_idx), .top_mag(top_mag),
    .frame_done(frame_done), .frame_error(frame_error)
  );

  spectrum_bin_ranker #(.SCALER(0)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .bin_data(bin_data), .bin_last(bin_last), .hold_en(hold_en),
    .top_idx(top_idx0), .top_mag(top_mag0),
    .frame_done(frame_done0), .frame_error(frame_error0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_vec();
    for (int i = 0; i < 16; i++) begin
      re_v[i] = '0;
      im_v[i] = '0;
    end
  endtask

  task automatic load_frame_a();
    clear_vec();
    re_v[5] = 16'd100;
    im_v[5] = -16'sd60;
    re_v[9] = -16'sd80;
    im_v[2] = 16'd50;
  endtask

  // hold_en is inverted after bin 0 to show mid-frame changes are ignored.
  task automatic send_frame(input int nbins, input int last_at, input bit hold, input int gap_max);
    for (int i = 0; i < nbins; i++) begin
      int w;
      if (gap_max > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) step();
      end
      w = 0;
      while (!in_ready && w < 50) begin
        step();
        w++;
      end
      if (w >= 50) check("ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      bin_data = {re_v[i], im_v[i]};
      bin_last = (i == last_at);
      hold_en  = (i == 0) ? hold : !hold;
      step();
    end
    in_valid = 1'b0;
    bin_last = 1'b0;
  endtask

  task automatic check_publish(input string tag);
    check({tag, "_ready_t1"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_done_t1"}, {31'd0, frame_done}, 32'd0);
    step();
    check({tag, "_done_t2"}, {31'd0, frame_done}, 32'd0);
    step();
    check({tag, "_done_t3"}, {31'd0, frame_done}, 32'd1);
    check({tag, "_err_t3"}, {31'd0, frame_error}, 32'd0);
    step();
    check({tag, "_ready_t4"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_done_t4"}, {31'd0, frame_done}, 32'd0);
  endtask

  task automatic check_top(input string tag, input int i0, input int i1, input int i2,
                           input int m0, input int m1, input int m2);
    check({tag, "_idx0"}, {28'd0, top_idx[3:0]}, i0);
    check({tag, "_idx1"}, {28'd0, top_idx[7:4]}, i1);
    check({tag, "_idx2"}, {28'd0, top_idx[11:8]}, i2);
    check({tag, "_mag0"}, {15'd0, top_mag[16:0]}, m0);
    check({tag, "_mag1"}, {15'd0, top_mag[33:17]}, m1);
    check({tag, "_mag2"}, {15'd0, top_mag[50:34]}, m2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_idx"}, {20'd0, top_idx}, 32'd0);
    check({tag, "_mag_lo"}, top_mag[31:0], 32'd0);
    check({tag, "_mag_hi"}, {13'd0, top_mag[50:32]}, 32'd0);
    check({tag, "_done"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_err"}, {31'd0, frame_error}, 32'd0);
  endtask

  task automatic check_error_frame(input string tag);
    int seen_done;
    check({tag, "_err_t1"}, {31'd0, frame_error}, 32'd1);
    check({tag, "_done_t1"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_ready_t1"}, {31'd0, in_ready}, 32'd1);
    seen_done = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (frame_done) seen_done++;
    end
    check({tag, "_no_done"}, seen_done, 32'd0);
    check({tag, "_err_clear"}, {31'd0, frame_error}, 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    bin_data = '0;
    bin_last = 1'b0;
    hold_en  = 1'b0;
    repeat (3) step();
    check_reset_outputs("rst");
    reset = 1'b0;
    #1;
    check("rst_ready_after", {31'd0, in_ready}, 32'd1);

    load_frame_a();
    send_frame(16, 15, 1'b0, 0);
    check_publish("fa");
    check_top("fa", 5, 9, 2, 80, 40, 25);

    clear_vec();
    re_v[3] = 16'd128;
    im_v[7] = -16'sd128;
    send_frame(16, 15, 1'b0, 0);
    check_publish("tie");
    check_top("tie", 3, 7, 0, 64, 64, 0);

    clear_vec();
    re_v[4] = 16'd256;
    send_frame(16, 15, 1'b1, 0);
    check_publish("ph1");
    check_top("ph1", 4, 3, 7, 128, 56, 56);
    clear_vec();
    send_frame(16, 15, 1'b1, 0);
    check_publish("ph2");
    check_top("ph2", 4, 3, 7, 112, 49, 49);
    send_frame(16, 15, 1'b1, 0);
    check_publish("ph3");
    check_top("ph3", 4, 3, 7, 98, 43, 43);

    clear_vec();
    re_v[0] = 16'h8000;
    im_v[0] = 16'h8000;
    send_frame(16, 15, 1'b0, 0);
    check_publish("ext");
    check_top("ext", 0, 1, 2, 32768, 0, 0);
    check("ext_s0_idx0", {28'd0, top_idx0[3:0]}, 32'd0);
    check("ext_s0_mag0", {15'd0, top_mag0[16:0]}, 32'd65536);

    load_frame_a();
    send_frame(11, 10, 1'b0, 0);
    check_error_frame("early_last");
    check_top("early_keep", 0, 1, 2, 32768, 0, 0);

    clear_vec();
    re_v[1] = 16'd20;
    send_frame(16, -1, 1'b0, 0);
    check_error_frame("no_last");
    check_top("nolast_keep", 0, 1, 2, 32768, 0, 0);

    load_frame_a();
    send_frame(16, 15, 1'b0, 2);
    check_publish("post_err");
    check_top("post_err", 5, 9, 2, 80, 40, 25);

    clear_vec();
    re_v[6] = 16'd300;
    send_frame(8, -1, 1'b1, 3);
    reset = 1'b1;
    repeat (2) step();
    check_reset_outputs("mid_rst");
    reset = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    load_frame_a();
    send_frame(16, 15, 1'b0, 3);
    check_publish("gap");
    check_top("gap", 5, 9, 2, 80, 40, 25);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
